// File: rtl/id_ex_stage_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_if
//
// Purpose:
//   Bundles the ID-side inputs and EX-side outputs of the ID/EX pipeline
//   register. The clock and reset stay as plain ports on the stage itself.
//
// Signal summary:
//   ID -> stage : id_valid, id_uses_rt, id_rs/rt/rd, id_* control bits,
//                 id_aluop, id_pc4, id_rdata1, id_rdata2, id_imm, flush
//   stage -> EX : idex_valid, idex_* control bits, idex_aluop, idex_pc4,
//                 idex_rdata1, idex_rdata2, idex_imm, idex_regs/regt/regd
//   stage -> IF : pc_write, ifid_write (combinational hazard stall)
//   status      : stall_cnt (saturating load-use bubble count)
//
// Modports:
//   master : the pipeline surroundings (decode stage, fetch, EX consumers)
//   slave  : the ID/EX stage register itself
// ---------------------------------------------------------------------------
interface id_ex_stage_reg_if #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
);
    // ID-stage fields
    logic               id_valid;
    logic               id_uses_rt;
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic [4:0]         id_rd;
    logic               id_regwrite;
    logic               id_memtoreg;
    logic               id_memread;
    logic               id_memwrite;
    logic               id_alusrc;
    logic               id_regdst;
    logic [ALUOP_W-1:0] id_aluop;
    logic [DATA_W-1:0]  id_pc4;
    logic [DATA_W-1:0]  id_rdata1;
    logic [DATA_W-1:0]  id_rdata2;
    logic [DATA_W-1:0]  id_imm;
    logic               flush;

    // EX-stage fields
    logic               idex_valid;
    logic               idex_regwrite;
    logic               idex_memtoreg;
    logic               idex_memread;
    logic               idex_memwrite;
    logic               idex_alusrc;
    logic               idex_regdst;
    logic [ALUOP_W-1:0] idex_aluop;
    logic [DATA_W-1:0]  idex_pc4;
    logic [DATA_W-1:0]  idex_rdata1;
    logic [DATA_W-1:0]  idex_rdata2;
    logic [DATA_W-1:0]  idex_imm;
    logic [4:0]         idex_regs;
    logic [4:0]         idex_regt;
    logic [4:0]         idex_regd;

    // Hazard outputs and status
    logic               pc_write;
    logic               ifid_write;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output id_valid, id_uses_rt, id_rs, id_rt, id_rd,
               id_regwrite, id_memtoreg, id_memread, id_memwrite,
               id_alusrc, id_regdst, id_aluop,
               id_pc4, id_rdata1, id_rdata2, id_imm, flush,
        input  idex_valid, idex_regwrite, idex_memtoreg, idex_memread,
               idex_memwrite, idex_alusrc, idex_regdst, idex_aluop,
               idex_pc4, idex_rdata1, idex_rdata2, idex_imm,
               idex_regs, idex_regt, idex_regd,
               pc_write, ifid_write, stall_cnt
    );

    modport slave (
        input  id_valid, id_uses_rt, id_rs, id_rt, id_rd,
               id_regwrite, id_memtoreg, id_memread, id_memwrite,
               id_alusrc, id_regdst, id_aluop,
               id_pc4, id_rdata1, id_rdata2, id_imm, flush,
        output idex_valid, idex_regwrite, idex_memtoreg, idex_memread,
               idex_memwrite, idex_alusrc, idex_regdst, idex_aluop,
               idex_pc4, idex_rdata1, idex_rdata2, idex_imm,
               idex_regs, idex_regt, idex_regd,
               pc_write, ifid_write, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// Purpose:
//   ID/EX pipeline register of a classic 5-stage pipeline. Captures the
//   decoded ID fields every cycle and presents them to EX one cycle later.
//   Also hosts the load-use hazard detector: when the instruction in EX is a
//   load whose destination (rt) is a source of the instruction in ID, PC and
//   IF/ID are held for one cycle and a bubble is inserted into EX. A branch /
//   jump flush from downstream squashes the ID instruction and takes
//   priority over the hazard.
//
// Ports:
//   clk_i : clock, rising edge
//   rst_n : asynchronous active-low reset, clears every registered output
//   bus   : id_ex_stage_reg_if.slave (ID inputs, EX outputs, pc_write,
//           ifid_write, stall_cnt)
//
// Parameters:
//   DATA_W  : width of read data, immediate and pc+4 fields
//   ALUOP_W : width of the ALU op control field
//   CNT_W   : width of the saturating load-use bubble counter
//   (must match the parameters of the connected interface instance)
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    id_ex_stage_reg_if.slave  bus
);

    // Everything the EX stage sees, kept as one record so that a bubble is
    // simply "the whole record is zero".
    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memtoreg;
        logic               memread;
        logic               memwrite;
        logic               alusrc;
        logic               regdst;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  pc4;
        logic [DATA_W-1:0]  rdata1;
        logic [DATA_W-1:0]  rdata2;
        logic [DATA_W-1:0]  imm;
        logic [4:0]         regs;
        logic [4:0]         regt;
        logic [4:0]         regd;
    } ex_fields_t;

    ex_fields_t       ex_q;
    ex_fields_t       ex_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic             rt_nonzero;
    logic             rs_match;
    logic             rt_match;
    logic             hazard;
    logic             bubble;
    logic             cnt_saturated;

    // -----------------------------------------------------------------------
    // Load-use hazard detection
    //
    // Purely a function of the registered EX state and the current ID
    // inputs. Register 0 is hard-wired to zero, so a load targeting it can
    // never create a real dependency. The rt comparison only matters when
    // the ID instruction actually reads rt. Flush masks the hazard: the ID
    // instruction is being squashed anyway, so stalling for it would only
    // lose a cycle.
    // -----------------------------------------------------------------------
    assign rt_nonzero = (ex_q.regt != 5'd0);
    assign rs_match   = (ex_q.regt == bus.id_rs);
    assign rt_match   = bus.id_uses_rt && (ex_q.regt == bus.id_rt);

    assign hazard = ex_q.memread && bus.id_valid && !bus.flush &&
                    rt_nonzero && (rs_match || rt_match);

    assign bus.pc_write   = !hazard;
    assign bus.ifid_write = !hazard;

    // Flush and hazard both turn into the same all-zero bubble.
    assign bubble = bus.flush || hazard;

    assign cnt_saturated = (stall_cnt_q == {CNT_W{1'b1}});

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        ex_d        = '0;
        stall_cnt_d = stall_cnt_q;

        if (!bubble) begin
            // Control bits are qualified by id_valid so an empty ID slot can
            // never write a register or touch memory from EX onward.
            ex_d.valid    = bus.id_valid;
            ex_d.regwrite = bus.id_valid && bus.id_regwrite;
            ex_d.memtoreg = bus.id_valid && bus.id_memtoreg;
            ex_d.memread  = bus.id_valid && bus.id_memread;
            ex_d.memwrite = bus.id_valid && bus.id_memwrite;
            ex_d.alusrc   = bus.id_valid && bus.id_alusrc;
            ex_d.regdst   = bus.id_valid && bus.id_regdst;
            ex_d.aluop    = bus.id_aluop;
            ex_d.pc4      = bus.id_pc4;
            ex_d.rdata1   = bus.id_rdata1;
            ex_d.rdata2   = bus.id_rdata2;
            ex_d.imm      = bus.id_imm;
            ex_d.regs     = bus.id_rs;
            ex_d.regt     = bus.id_rt;
            ex_d.regd     = bus.id_rd;
        end

        // Only load-use bubbles are counted; flush bubbles are excluded
        // because hazard is already masked by flush. The count sticks at
        // all-ones rather than wrapping.
        if (hazard && !cnt_saturated) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their _d values from the same edge, independent of order.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign bus.idex_valid    = ex_q.valid;
    assign bus.idex_regwrite = ex_q.regwrite;
    assign bus.idex_memtoreg = ex_q.memtoreg;
    assign bus.idex_memread  = ex_q.memread;
    assign bus.idex_memwrite = ex_q.memwrite;
    assign bus.idex_alusrc   = ex_q.alusrc;
    assign bus.idex_regdst   = ex_q.regdst;
    assign bus.idex_aluop    = ex_q.aluop;
    assign bus.idex_pc4      = ex_q.pc4;
    assign bus.idex_rdata1   = ex_q.rdata1;
    assign bus.idex_rdata2   = ex_q.rdata2;
    assign bus.idex_imm      = ex_q.imm;
    assign bus.idex_regs     = ex_q.regs;
    assign bus.idex_regt     = ex_q.regt;
    assign bus.idex_regd     = ex_q.regd;
    assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Directed bench for id_ex_stage_reg. The stall counter is built 2 bits wide
// so saturation is reachable in a handful of load-use pairs. Inputs change
// 1 time unit after a rising edge; outputs are sampled 1 unit later (for
// combinational hazard outputs) or 1 unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

    localparam int DATA_W  = 32;
    localparam int ALUOP_W = 3;
    localparam int CNT_W   = 2;

    logic clk_i;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    id_ex_stage_reg_if #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage_reg #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Watchdog: the directed sequence is a few hundred time units long.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present an ID instruction; data fields default to zero.
    task automatic set_id(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic memread, input logic regwrite,
                          input logic uses_rt);
        bus.id_valid    = valid;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_memread  = memread;
        bus.id_regwrite = regwrite;
        bus.id_uses_rt  = uses_rt;
        bus.id_memtoreg = memread;
        bus.id_memwrite = 1'b0;
        bus.id_alusrc   = 1'b0;
        bus.id_regdst   = 1'b0;
        bus.id_aluop    = '0;
        bus.id_pc4      = '0;
        bus.id_rdata1   = '0;
        bus.id_rdata2   = '0;
        bus.id_imm      = '0;
        bus.flush       = 1'b0;
    endtask

    // One load (writes r<dst>) followed by a consumer reading r<dst> in rs.
    // Returns after the bubble edge.
    task automatic load_use_pair(input logic [4:0] dst);
        set_id(1'b1, 5'd1, dst, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, dst, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1);
        tick();
    endtask

    logic [CNT_W-1:0] sat_exp [5];

    initial begin
        sat_exp[0] = 2'd1;
        sat_exp[1] = 2'd2;
        sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3;
        sat_exp[4] = 2'd3;

        // ---------------- Reset ----------------
        rst_n = 1'b0;
        set_id(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1);
        #12;
        check("rst_valid",    bus.idex_valid,    1'b0);
        check("rst_memread",  bus.idex_memread,  1'b0);
        check("rst_regt",     bus.idex_regt,     5'd0);
        check("rst_stall",    bus.stall_cnt,     2'd0);
        check("rst_pc_write", bus.pc_write,      1'b1);
        check("rst_ifid",     bus.ifid_write,    1'b1);

        // ---------------- 1: basic load ----------------
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b1, 1'b1);
        bus.id_aluop  = 3'd2;
        bus.id_rdata1 = 32'h11;
        bus.id_imm    = 32'hFFFF_FFF0;
        @(negedge clk_i);
        rst_n = 1'b1;
        tick();
        check("t1_regs",     bus.idex_regs,     5'd3);
        check("t1_regt",     bus.idex_regt,     5'd4);
        check("t1_regd",     bus.idex_regd,     5'd5);
        check("t1_regwrite", bus.idex_regwrite, 1'b1);
        check("t1_aluop",    bus.idex_aluop,    3'd2);
        check("t1_rdata1",   bus.idex_rdata1,   32'h11);
        check("t1_imm",      bus.idex_imm,      32'hFFFF_FFF0);
        check("t1_valid",    bus.idex_valid,    1'b1);
        check("t1_pc_write", bus.pc_write,      1'b1);

        // ---------------- 2: load-use stall ----------------
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check("t2_ex_memread", bus.idex_memread, 1'b1);
        set_id(1'b1, 5'd8, 5'd2, 5'd6, 1'b0, 1'b1, 1'b1);
        #1;
        check("t2_pc_write_stall", bus.pc_write,   1'b0);
        check("t2_ifid_stall",     bus.ifid_write, 1'b0);
        tick();
        check("t2_bub_valid",    bus.idex_valid,    1'b0);
        check("t2_bub_memread",  bus.idex_memread,  1'b0);
        check("t2_bub_regwrite", bus.idex_regwrite, 1'b0);
        check("t2_bub_regs",     bus.idex_regs,     5'd0);
        check("t2_bub_regt",     bus.idex_regt,     5'd0);
        check("t2_stall_cnt",    bus.stall_cnt,     2'd1);
        check("t2_pc_write_rel", bus.pc_write,      1'b1);
        tick();
        check("t2_load_regs",  bus.idex_regs,  5'd8);
        check("t2_load_regd",  bus.idex_regd,  5'd6);
        check("t2_load_valid", bus.idex_valid, 1'b1);
        check("t2_stall_hold", bus.stall_cnt,  2'd1);

        // ---------------- 3: no false stalls ----------------
        // 3a: load to r0, consumer reads r0
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1);
        #1;
        check("t3a_r0_no_stall", bus.pc_write, 1'b1);
        // 3b: load to r9, consumer has rt=9 but does not read rt
        set_id(1'b1, 5'd1, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd2, 5'd9, 5'd4, 1'b0, 1'b1, 1'b0);
        #1;
        check("t3b_rt_unused", bus.pc_write, 1'b1);
        bus.id_uses_rt = 1'b1;
        #1;
        check("t3b_rt_used", bus.pc_write, 1'b0);
        bus.id_uses_rt = 1'b0;
        // 3c: non-load in EX writing r8, consumer reads r8
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("t3c_no_bubble_cnt", bus.stall_cnt, 2'd1);
        set_id(1'b1, 5'd8, 5'd8, 5'd4, 1'b0, 1'b1, 1'b1);
        #1;
        check("t3c_no_memread", bus.pc_write, 1'b1);
        // 3d: invalid ID slot loads data but zeroes control bits
        set_id(1'b0, 5'd12, 5'd13, 5'd14, 1'b1, 1'b1, 1'b0);
        bus.id_memwrite = 1'b1;
        tick();
        check("t3d_valid",    bus.idex_valid,    1'b0);
        check("t3d_regwrite", bus.idex_regwrite, 1'b0);
        check("t3d_memread",  bus.idex_memread,  1'b0);
        check("t3d_memwrite", bus.idex_memwrite, 1'b0);
        check("t3d_regd",     bus.idex_regd,     5'd14);

        // ---------------- 4: flush beats hazard ----------------
        set_id(1'b1, 5'd1, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1);
        bus.id_rdata1 = 32'hDEAD_BEEF;
        bus.flush = 1'b1;
        #1;
        check("t4_pc_write", bus.pc_write,   1'b1);
        check("t4_ifid",     bus.ifid_write, 1'b1);
        tick();
        check("t4_bub_valid",  bus.idex_valid,  1'b0);
        check("t4_bub_regs",   bus.idex_regs,   5'd0);
        check("t4_bub_rdata1", bus.idex_rdata1, 32'h0);
        check("t4_stall_cnt",  bus.stall_cnt,   2'd1);

        // ---------------- 5: saturation ----------------
        rst_n = 1'b0;
        #1;
        check("t5_rst_cnt", bus.stall_cnt, 2'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            load_use_pair(5'd10);
            check($sformatf("t5_sat_%0d", k), bus.stall_cnt, sat_exp[k]);
            tick(); // consumer re-presented and loaded
        end

        // ---------------- 6: async reset mid-stall ----------------
        rst_n = 1'b0;
        #1;
        @(negedge clk_i);
        rst_n = 1'b1;
        load_use_pair(5'd10);
        tick();
        load_use_pair(5'd10);
        tick();
        check("t6_pre_cnt", bus.stall_cnt, 2'd2);
        set_id(1'b1, 5'd1, 5'd10, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd10, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1);
        #1;
        check("t6_stalling", bus.pc_write, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_memread",  bus.idex_memread, 1'b0);
        check("t6_rst_valid",    bus.idex_valid,   1'b0);
        check("t6_rst_regt",     bus.idex_regt,    5'd0);
        check("t6_rst_cnt",      bus.stall_cnt,    2'd0);
        check("t6_rst_pc_write", bus.pc_write,     1'b1);
        @(negedge clk_i);
        rst_n = 1'b1;
        tick();
        check("t6_post_regs",  bus.idex_regs,  5'd10);
        check("t6_post_valid", bus.idex_valid, 1'b1);
        check("t6_post_cnt",   bus.stall_cnt,  2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
